// File: rtl/sha256_msg_sched_ctrl.sv
// SHA-256 message schedule sequencer: load 16 words, then expand W[16..ROUNDS-1] with a 4:2 carry-save row.
// Define MSG_SCHED_SINGLE_CYCLE_EN to fold the compress and final add into a single COMP state.
module sha256_msg_sched_ctrl #(
  parameter int ROUNDS = 64,
  parameter int IDX_W  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_word,
  output logic [IDX_W-1:0] out_idx,
  output logic             busy,
  output logic             done
);

`ifdef MSG_SCHED_SINGLE_CYCLE_EN
  typedef enum logic [2:0] {IDLE, LOAD, COMP, DRAIN} state_t;
  localparam state_t COMP_ENTRY = COMP;
  localparam state_t COMP_EMIT  = COMP;
`else
  typedef enum logic [2:0] {IDLE, LOAD, COMP_A, COMP_B, DRAIN} state_t;
  localparam state_t COMP_ENTRY = COMP_A;
  localparam state_t COMP_EMIT  = COMP_B;
`endif

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);
  localparam logic [IDX_W-1:0] LOAD_END = IDX_W'(15);

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
  endfunction

  state_t           state_reg;
  logic [IDX_W-1:0] t_reg;
  logic             out_valid_reg;
  logic [31:0]      out_word_reg;
  logic [IDX_W-1:0] out_idx_reg;

  logic [31:0] buf_mem [16];
  logic [3:0]  slot;
  logic [31:0] op_a, op_b, op_c, op_d;
  logic [31:0] sum_vec, car_vec;
  logic [30:0] cout_vec;
  logic [31:0] w_new;
  logic        out_free, in_fire, comp_fire, wr_en;
  logic [31:0] wr_data;

  assign out_free  = !out_valid_reg || out_ready;
  assign in_fire   = (state_reg == LOAD) && in_valid && out_free;
  assign comp_fire = (state_reg == COMP_EMIT) && out_free;
  assign wr_en     = in_fire || comp_fire;
  assign wr_data   = in_fire ? in_word : w_new;

  // Slot t mod 16 still holds W[t-16] until this word overwrites it.
  assign slot = t_reg[3:0];
  assign op_a = sig1(buf_mem[slot - 4'd2]);
  assign op_b = buf_mem[slot - 4'd7];
  assign op_c = sig0(buf_mem[slot - 4'd15]);
  assign op_d = buf_mem[slot];

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_cell
      logic fa_sum;
      logic cin;
      if (gi == 0) begin : g_first
        assign cin = 1'b0;
      end else begin : g_chain
        assign cin = cout_vec[gi-1];
      end
      // cout depends only on a,b,c so the lateral chain never ripples.
      if (gi < 31) begin : g_cout
        assign cout_vec[gi] = (op_a[gi] & op_b[gi]) | (op_a[gi] & op_c[gi]) | (op_b[gi] & op_c[gi]);
      end
      assign fa_sum       = op_a[gi] ^ op_b[gi] ^ op_c[gi];
      assign sum_vec[gi]  = fa_sum ^ op_d[gi] ^ cin;
      assign car_vec[gi]  = (fa_sum & op_d[gi]) | (fa_sum & cin) | (op_d[gi] & cin);
    end
  endgenerate

`ifdef MSG_SCHED_SINGLE_CYCLE_EN
  assign w_new = sum_vec + (car_vec << 1);
`else
  logic [31:0] s_reg, c_reg;

  always_ff @(posedge clk) begin
    if (state_reg == COMP_A) begin
      s_reg <= sum_vec;
      c_reg <= car_vec;
    end
  end

  assign w_new = s_reg + (c_reg << 1);
`endif

  always_ff @(posedge clk) begin
    if (wr_en) buf_mem[slot] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      t_reg         <= '0;
      out_valid_reg <= 1'b0;
      out_word_reg  <= '0;
      out_idx_reg   <= '0;
    end else begin
      if (out_valid_reg && out_ready) out_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= LOAD;
            t_reg     <= '0;
          end
        end
        LOAD: begin
          if (in_fire) begin
            out_valid_reg <= 1'b1;
            out_word_reg  <= in_word;
            out_idx_reg   <= t_reg;
            t_reg         <= t_reg + 1'b1;
            if (t_reg == LOAD_END) state_reg <= COMP_ENTRY;
          end
        end
`ifndef MSG_SCHED_SINGLE_CYCLE_EN
        COMP_A: state_reg <= COMP_B;
`endif
        COMP_EMIT: begin
          if (out_free) begin
            out_valid_reg <= 1'b1;
            out_word_reg  <= w_new;
            out_idx_reg   <= t_reg;
            t_reg         <= t_reg + 1'b1;
            state_reg     <= (t_reg == LAST_IDX) ? DRAIN : COMP_ENTRY;
          end
        end
        DRAIN: begin
          if (out_valid_reg && out_ready) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == LOAD) && out_free;
  assign out_valid = out_valid_reg;
  assign out_word  = out_word_reg;
  assign out_idx   = out_idx_reg;
  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DRAIN) && out_valid_reg && out_ready;

endmodule

// File: tb/tb_sha256_msg_sched_ctrl.sv
// Directed bench for sha256_msg_sched_ctrl: "abc" block, stalls, mid-block reset and a ROUNDS=17 instance.
module tb_sha256_msg_sched_ctrl;

`ifdef MSG_SCHED_SINGLE_CYCLE_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif
  localparam int R = 64;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_ready, out_valid, out_ready, busy, done;
  logic [31:0] in_word, out_word;
  logic [5:0]  out_idx;

  logic        z_start, z_in_valid, z_in_ready, z_out_valid, z_out_ready, z_busy, z_done;
  logic [31:0] z_in_word, z_out_word;
  logic [4:0]  z_out_idx;

  always #5 clk = ~clk;

  sha256_msg_sched_ctrl #(.ROUNDS(64), .IDX_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_word(in_word), .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_idx(out_idx), .busy(busy), .done(done)
  );

  sha256_msg_sched_ctrl #(.ROUNDS(17), .IDX_W(5)) dut17 (
    .clk(clk), .rst(rst), .start(z_start), .in_valid(z_in_valid), .in_ready(z_in_ready),
    .in_word(z_in_word), .out_valid(z_out_valid), .out_ready(z_out_ready), .out_word(z_out_word),
    .out_idx(z_out_idx), .busy(z_busy), .done(z_done)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int exp_idx, done_cnt, acc15, v16, v17;
  logic        hold_pend;
  logic [31:0] hold_word;
  logic [5:0]  hold_idx;
  logic [31:0] blk [16];
  logic [31:0] ref_w [64];
  logic [31:0] cap [64];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
  endfunction

  task automatic build_ref();
    for (int i = 0; i < 16; i++) ref_w[i] = blk[i];
    for (int i = 16; i < 64; i++)
      ref_w[i] = ssig1(ref_w[i-2]) + ref_w[i-7] + ssig0(ref_w[i-15]) + ref_w[i-16];
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Called #2 after an edge with this cycle's inputs settled.
  task automatic mon();
    if (hold_pend) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_word", out_word, hold_word);
      chk("hold_idx", out_idx, hold_idx);
    end
    if (out_valid && !out_ready) chk("in_ready_blocked", in_ready, 0);
    if (out_valid && out_idx == 6'd16 && v16 < 0) v16 = cyc;
    if (out_valid && out_idx == 6'd17 && v17 < 0) v17 = cyc;
    if (out_valid && out_ready) begin
      if (exp_idx < 64) begin
        chk("idx", out_idx, exp_idx);
        chk("word", out_word, ref_w[exp_idx]);
        cap[exp_idx] = out_word;
      end else begin
        chk("extra_word", exp_idx, 63);
      end
      $display("word idx=%0d val=%08h", out_idx, out_word);
      exp_idx++;
    end
    if (done) begin
      done_cnt++;
      chk("done_idx", out_idx, R - 1);
    end
    hold_pend = out_valid && !out_ready;
    hold_word = out_word;
    hold_idx  = out_idx;
  endtask

  task automatic run_block(input int stall_mode, input int bp_mode, input int rst_at);
    int  feed, bp_cnt, st_cnt;
    bit  fin, did_rst;
    feed = 0; bp_cnt = 0; st_cnt = 0; fin = 0; did_rst = 0;
    exp_idx = 0; done_cnt = 0; acc15 = -1; v16 = -1; v17 = -1; hold_pend = 0;
    build_ref();
    // start and in_valid together in IDLE: the word must not be taken.
    start = 1; in_valid = 1; in_word = blk[0]; out_ready = 1;
    #1;
    chk("idle_in_ready", in_ready, 0);
    chk("idle_busy", busy, 0);
    edge_step();
    start = 0;
    for (int b = 0; b < 3000 && !fin; b++) begin
      if (feed < 16) begin
        in_valid = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        in_word  = blk[feed];
      end else begin
        in_valid = 0;
        in_word  = 0;
      end
      out_ready = 1;
      if (stall_mode && feed == 2 && st_cnt < 8) begin
        out_ready = 0;
        st_cnt++;
      end
      if (bp_mode && out_valid && out_idx == 6'd20 && bp_cnt < 5) begin
        out_ready = 0;
        bp_cnt++;
      end
      if (rst_at >= 0 && out_valid && out_idx == 6'(rst_at)) rst = 1;
      #1;
      mon();
      if (in_valid && in_ready) begin
        if (feed == 15) acc15 = cyc + 1;
        feed++;
      end
      if (done) fin = 1;
      edge_step();
      if (rst) begin
        rst = 0;
        fin = 1;
        did_rst = 1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_idx", out_idx, 0);
      end
    end
    in_valid = 0;
    if (!fin) chk("timeout", 0, 1);
    if (!did_rst) begin
      chk("busy_after_done", busy, 0);
      chk("done_width", done, 0);
      chk("word_count", exp_idx, R);
      chk("done_count", done_cnt, 1);
    end
  endtask

  initial begin
    int zcnt, zdone;
    bit zfin;
    rst = 1; start = 0; in_valid = 0; in_word = 0; out_ready = 0;
    z_start = 0; z_in_valid = 0; z_in_word = 0; z_out_ready = 0;
    hold_pend = 0;
    repeat (3) edge_step();
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_word", out_word, 0);
    chk("reset_out_idx", out_idx, 0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    rst = 0;
    edge_step();

    // "abc" block, out_ready held high
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
    run_block(0, 0, -1);
    chk("abc_w16", cap[16], 32'h61626380);
    chk("abc_w17", cap[17], 32'h000F0000);
    chk("lat_w16", v16 - acc15, LAT);
    chk("lat_w17", v17 - v16, LAT);
    edge_step();

    // load stall plus backpressure at idx 20
    run_block(1, 1, -1);
    edge_step();

    // mid-block reset at idx 30, then a full run of the same block
    for (int i = 0; i < 16; i++) blk[i] = (32'h9E3779B9 * (i + 1)) ^ 32'hA5A50F0F;
    run_block(0, 0, 30);
    edge_step();
    run_block(0, 1, -1);
    edge_step();

    // ROUNDS=17 instance with all-zero input
    zcnt = 0; zdone = 0; zfin = 0;
    z_start = 1;
    edge_step();
    z_start = 0; z_in_valid = 1; z_in_word = 0; z_out_ready = 1;
    for (int b = 0; b < 300 && !zfin; b++) begin
      #1;
      if (z_out_valid && z_out_ready) begin
        chk("r17_idx", z_out_idx, zcnt);
        chk("r17_word", z_out_word, 0);
        $display("r17 word idx=%0d val=%08h", z_out_idx, z_out_word);
        zcnt++;
      end
      if (z_done) begin
        chk("r17_done_idx", z_out_idx, 16);
        zdone++;
        zfin = 1;
      end
      edge_step();
    end
    z_in_valid = 0;
    if (!zfin) chk("r17_timeout", 0, 1);
    chk("r17_count", zcnt, 17);
    chk("r17_done_count", zdone, 1);
    chk("r17_busy_after", z_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
